// File: rtl/fetch_pkg.sv
// fetch_pkg: opcodes, PC-select codes, FSM states and the
// default instruction/address widths shared by fetch_ctrl.
package fetch_pkg;

  localparam int IW_DEF = 16;
  localparam int AW_DEF = 6;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU0 = 4'h1;
  localparam logic [3:0] OP_ALU1 = 4'h7;
  localparam logic [3:0] OP_BZ   = 4'h8;
  localparam logic [3:0] OP_BNZ  = 4'h9;
  localparam logic [3:0] OP_JR   = 4'hA;
  localparam logic [3:0] OP_BRA  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;
  localparam logic [1:0] PS_JR   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  function automatic logic is_alu(
    input logic [3:0] op
  );
    return (op >= OP_ALU0) && (op <= OP_ALU1);
  endfunction

endpackage

// File: rtl/fetch_decode.sv
// fetch_decode: EXEC-cycle decode of opcode -> ps/offset/a_out/ex_valid.
// Ports: op, imm, zero_flag, rf_a_data, in_exec in; ps, offset, a_out, ex_valid, is_halt, is_illegal out.
module fetch_decode
  import fetch_pkg::*;
(
  input  logic [3:0] op,
  input  logic [3:0] imm,
  input  logic       zero_flag,
  input  logic [3:0] rf_a_data,
  input  logic       in_exec,
  output logic [1:0] ps,
  output logic [3:0] offset,
  output logic [3:0] a_out,
  output logic       ex_valid,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    ps         = PS_HOLD;
    offset     = '0;
    a_out      = '0;
    ex_valid   = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    if (in_exec) begin
      unique case (1'b1)
        op == OP_NOP: ps = PS_INC;
        is_alu(op): begin
          ps       = PS_INC;
          ex_valid = 1'b1;
        end
        op == OP_BZ: begin
          ps     = zero_flag ? PS_BR : PS_INC;
          offset = zero_flag ? imm : 4'd0;
        end
        op == OP_BNZ: begin
          ps     = zero_flag ? PS_INC : PS_BR;
          offset = zero_flag ? 4'd0 : imm;
        end
        op == OP_JR: begin
          ps    = PS_JR;
          a_out = rf_a_data;
        end
        op == OP_BRA: begin
          ps     = PS_BR;
          offset = imm;
        end
        op == OP_HALT: is_halt = 1'b1;
        default: begin
`ifdef FETCH_ILLEGAL_TRAP_EN
          is_illegal = 1'b1;
`else
          ps = PS_INC;
`endif
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: multicycle fetch/decode/exec sequencer driving program_counter.
// Ports: clk_main, reset_n, pc, imem_*, zero_flag, rf_a_*, ps, offset, a_out, ir, ex_valid, halted [, illegal when FETCH_ILLEGAL_TRAP_EN].
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk_main,
  input  logic          reset_n,
  input  logic [AW-1:0] pc,
  output logic [AW-1:0] imem_addr,
  output logic          imem_req,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_data,
  input  logic          zero_flag,
  output logic [3:0]    rf_a_addr,
  input  logic [3:0]    rf_a_data,
  output logic [1:0]    ps,
  output logic [3:0]    offset,
  output logic [3:0]    a_out,
  output logic [IW-1:0] ir,
  output logic          ex_valid,
  output logic          halted
`ifdef FETCH_ILLEGAL_TRAP_EN
  ,
  output logic          illegal
`endif
);

  state_t state, state_nxt;
  logic   in_exec;
  logic   is_halt;
  logic   is_illegal;

  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n)                          ir <= '0;
    else if (state == S_FETCH && imem_ack) ir <= imem_data;
  end

`ifdef FETCH_ILLEGAL_TRAP_EN
  always_ff @(posedge clk_main or negedge reset_n) begin
    if (!reset_n)       illegal <= 1'b0;
    else if (is_illegal) illegal <= 1'b1;
  end
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  if (imem_ack) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = (is_halt || is_illegal) ? S_HALT : S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Request is a pure state decode so an async reset drops it at once.
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = imem_req ? pc : '0;
  assign halted    = (state == S_HALT);
  assign in_exec   = (state == S_EXEC);
  assign rf_a_addr = ir[7:4];

  fetch_decode u_dec (
    .op         (ir[IW-1 -: 4]),
    .imm        (ir[3:0]),
    .zero_flag  (zero_flag),
    .rf_a_data  (rf_a_data),
    .in_exec    (in_exec),
    .ps         (ps),
    .offset     (offset),
    .a_out      (a_out),
    .ex_valid   (ex_valid),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: random + directed bench with an instruction-level model
// of fetch_ctrl, a behavioural program_counter, memory and register file.
module tb_fetch_ctrl;

  logic        clk_main;
  logic        reset_n;
  logic [5:0]  pc;
  logic [5:0]  imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        zero_flag;
  logic [3:0]  rf_a_addr;
  logic [3:0]  rf_a_data;
  logic [1:0]  ps;
  logic [3:0]  offset;
  logic [3:0]  a_out;
  logic [15:0] ir;
  logic        ex_valid;
  logic        halted;
`ifdef FETCH_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  fetch_ctrl dut (
    .clk_main  (clk_main),
    .reset_n   (reset_n),
    .pc        (pc),
    .imem_addr (imem_addr),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .zero_flag (zero_flag),
    .rf_a_addr (rf_a_addr),
    .rf_a_data (rf_a_data),
    .ps        (ps),
    .offset    (offset),
    .a_out     (a_out),
    .ir        (ir),
    .ex_valid  (ex_valid),
    .halted    (halted)
`ifdef FETCH_ILLEGAL_TRAP_EN
    ,
    .illegal   (illegal)
`endif
  );

  initial clk_main = 1'b0;
  always #5 clk_main = ~clk_main;

  logic [15:0] imem [64];
  logic [3:0]  regs [16];
  logic [5:0]  pc_init;

  assign imem_data = imem[imem_addr];
  assign rf_a_data = regs[rf_a_addr];

  // Environment program_counter
  always @(posedge clk_main or negedge reset_n) begin
    if (!reset_n) pc <= pc_init;
    else begin
      case (ps)
        2'b01:   pc <= pc + 6'd1;
        2'b10:   pc <= pc + 6'(offset) + 6'd1;
        2'b11:   pc <= pc + 6'(a_out);
        default: pc <= pc;
      endcase
    end
  end

  int cnt = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    cnt++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction-level model state
  logic        m_halt, m_acked, m_ill;
  int          m_sa;
  logic [15:0] m_ir;
  logic [5:0]  m_pc;
  int          cur_wait, ack_wait;
  int          zf_mode;
  logic        rand_ack;

  // Logs per cycle after reset release
  int          cyc, n_req, n_ps, n_ex;
  logic [1:0]  ps_at [64];
  logic [15:0] ir_at [64];
  logic [3:0]  last_a;
  logic [1:0]  last_ps;

  function automatic void ref_exec(
    input  logic [15:0] w,
    input  logic        z,
    input  logic [3:0]  a,
    output logic [1:0]  p,
    output logic [3:0]  o,
    output logic [3:0]  ao,
    output logic        ex,
    output logic        stop,
    output logic        ill
  );
    int op;
    op = int'(w[15:12]);
    p = 2'd1; o = 4'd0; ao = 4'd0; ex = 1'b0; stop = 1'b0; ill = 1'b0;
    if (op >= 1 && op <= 7) ex = 1'b1;
    else if (op == 8 && z) begin p = 2'd2; o = w[3:0]; end
    else if (op == 9 && !z) begin p = 2'd2; o = w[3:0]; end
    else if (op == 10) begin p = 2'd3; ao = a; end
    else if (op == 11) begin p = 2'd2; o = w[3:0]; end
    else if (op == 15) begin p = 2'd0; stop = 1'b1; end
    else if (op >= 12 && op <= 14) begin
`ifdef FETCH_ILLEGAL_TRAP_EN
      p = 2'd0; stop = 1'b1; ill = 1'b1;
`endif
    end
  endfunction

  task automatic step();
    logic       e_req, e_exec, e_ex, e_stop, e_ill;
    logic [1:0] e_ps;
    logic [3:0] e_off, e_a;
    logic [5:0] e_addr;
    @(posedge clk_main);
    #1;
    e_req = !m_halt && !m_acked;
    if (e_req) imem_ack = (cur_wait >= ack_wait);
    else       imem_ack = 1'($urandom_range(0, 1));
    zero_flag = (zf_mode == 2) ? 1'($urandom_range(0, 1)) : zf_mode[0];
    #1;
    e_exec = m_acked && (m_sa == 2);
    e_ps = 2'd0; e_off = 4'd0; e_a = 4'd0;
    e_ex = 1'b0; e_stop = 1'b0; e_ill = 1'b0;
    if (e_exec)
      ref_exec(m_ir, zero_flag, regs[m_ir[7:4]], e_ps, e_off, e_a, e_ex, e_stop, e_ill);
    e_addr = e_req ? m_pc : 6'd0;
    chk("imem_req", 16'(imem_req), 16'(e_req));
    chk("imem_addr", 16'(imem_addr), 16'(e_addr));
    chk("ps", 16'(ps), 16'(e_ps));
    chk("offset", 16'(offset), 16'(e_off));
    chk("a_out", 16'(a_out), 16'(e_a));
    chk("ex_valid", 16'(ex_valid), 16'(e_ex));
    chk("ir", ir, m_ir);
    chk("rf_a_addr", 16'(rf_a_addr), 16'(m_ir[7:4]));
    chk("halted", 16'(halted), 16'(m_halt));
`ifdef FETCH_ILLEGAL_TRAP_EN
    chk("illegal", 16'(illegal), 16'(m_ill));
`endif
    cyc++;
    if (cyc < 64) begin
      ps_at[cyc] = ps;
      ir_at[cyc] = ir;
    end
    if (imem_req) n_req++;
    if (ps != 2'd0) begin
      n_ps++;
      last_ps = ps;
      last_a  = a_out;
    end
    if (ex_valid) n_ex++;
    if (e_req) begin
      if (imem_ack) begin
        m_acked = 1'b1;
        m_sa = 1;
        m_ir = imem[m_pc];
        cur_wait = 0;
        if (rand_ack) ack_wait = $urandom_range(0, 3);
      end else cur_wait++;
    end else if (m_acked) begin
      if (m_sa == 2) begin
        m_acked = 1'b0;
        if (e_ps == 2'd1) m_pc = m_pc + 6'd1;
        else if (e_ps == 2'd2) m_pc = m_pc + 6'(e_off) + 6'd1;
        else if (e_ps == 2'd3) m_pc = m_pc + 6'(e_a);
        if (e_stop) m_halt = 1'b1;
        if (e_ill) m_ill = 1'b1;
      end else m_sa++;
    end
  endtask

  task automatic do_reset(input logic [5:0] start);
    pc_init = start;
    reset_n = 1'b0;
    imem_ack = 1'b0;
    zero_flag = 1'b0;
    repeat (2) @(posedge clk_main);
    #1;
    reset_n = 1'b1;
    #1;
    chk("rst_req", 16'(imem_req), 16'd0);
    chk("rst_addr", 16'(imem_addr), 16'd0);
    chk("rst_ps", 16'(ps), 16'd0);
    chk("rst_ir", ir, 16'd0);
    chk("rst_ex", 16'(ex_valid), 16'd0);
    chk("rst_halted", 16'(halted), 16'd0);
    chk("rst_off_a", 16'({offset, a_out}), 16'd0);
    m_halt = 1'b0; m_acked = 1'b0; m_ill = 1'b0; m_sa = 0;
    m_ir = 16'd0; m_pc = start; cur_wait = 0;
    cyc = 0; n_req = 0; n_ps = 0; n_ex = 0;
    last_a = 4'd0; last_ps = 2'd0;
  endtask

  task automatic run_until_halt(input int maxc);
    int k;
    k = 0;
    while (!m_halt && k < maxc) begin
      step();
      k++;
    end
    cnt++;
    if (!m_halt) begin
      fails++;
      $display("FAIL halt_timeout: no halt after %0d cycles", maxc);
    end
    step();
    step();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) imem[i] = 16'hF000;
  endtask

  initial begin
    reset_n = 1'b0;
    pc_init = 6'd0;
    imem_ack = 1'b0;
    zero_flag = 1'b0;
    zf_mode = 2;
    rand_ack = 1'b0;
    ack_wait = 0;
    for (int i = 0; i < 16; i++) regs[i] = 4'(i);

    // NOP, NOP, HALT with immediate ack
    clear_mem();
    imem[0] = 16'h0000;
    imem[1] = 16'h0000;
    do_reset(6'd0);
    run_until_halt(40);
    chk("t1_ps_c3", 16'(ps_at[3]), 16'd1);
    chk("t1_ps_c6", 16'(ps_at[6]), 16'd1);
    chk("t1_npulse", 16'(n_ps), 16'd2);
    chk("t1_pc", 16'(pc), 16'd2);
    chk("t1_halted", 16'(halted), 16'd1);

    // Ack delayed by 3 cycles
    clear_mem();
    imem[0] = 16'h0123;
    ack_wait = 3;
    do_reset(6'd0);
    run_until_halt(40);
    chk("t2_nreq", 16'(n_req), 16'd8);
    chk("t2_ir_c5", ir_at[5], 16'h0123);
    chk("t2_ir_c4", ir_at[4], 16'h0000);
    chk("t2_npulse", 16'(n_ps), 16'd1);
    ack_wait = 0;

    // BZ +5 at PC 10, taken and not taken
    clear_mem();
    imem[10] = 16'h8005;
    zf_mode = 1;
    do_reset(6'd10);
    run_until_halt(40);
    chk("t3_bz_taken", 16'(pc), 16'd16);
    zf_mode = 0;
    do_reset(6'd10);
    run_until_halt(40);
    chk("t3_bz_fall", 16'(pc), 16'd11);
    zf_mode = 2;

    // JR with ra=r2=7 at PC 60 wraps to 3
    clear_mem();
    regs[2] = 4'd7;
    imem[60] = 16'hA020;
    do_reset(6'd60);
    run_until_halt(40);
    chk("t4_pc_wrap", 16'(pc), 16'd3);
    chk("t4_ps", 16'(last_ps), 16'd3);
    chk("t4_a_out", 16'(last_a), 16'd7);

    // ALU op 0011
    clear_mem();
    imem[0] = 16'h3123;
    do_reset(6'd0);
    run_until_halt(40);
    chk("t5_nex", 16'(n_ex), 16'd1);
    chk("t5_ir_c2", ir_at[2], 16'h3123);
    chk("t5_ps_c3", 16'(ps_at[3]), 16'd1);

    // Unassigned opcode 1101
    clear_mem();
    imem[0] = 16'hD000;
    do_reset(6'd0);
    run_until_halt(40);
`ifdef FETCH_ILLEGAL_TRAP_EN
    chk("t6_pc", 16'(pc), 16'd0);
    chk("t6_illegal", 16'(illegal), 16'd1);
`else
    chk("t6_pc", 16'(pc), 16'd1);
`endif
    chk("t6_halted", 16'(halted), 16'd1);

    // Reset asserted mid-fetch
    clear_mem();
    imem[0] = 16'h0000;
    ack_wait = 10;
    do_reset(6'd5);
    step();
    step();
    #3;
    chk("t7_req_before", 16'(imem_req), 16'd1);
    pc_init = 6'd0;
    reset_n = 1'b0;
    #1;
    chk("t7_req_async", 16'(imem_req), 16'd0);
    chk("t7_addr_async", 16'(imem_addr), 16'd0);
    ack_wait = 0;

    // Randomized programs
    rand_ack = 1'b1;
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < 64; i++) begin
        imem[i] = 16'($urandom);
        if (imem[i][15:12] == 4'hF && $urandom_range(0, 3) != 0)
          imem[i][15:12] = 4'h0;
      end
      for (int i = 0; i < 16; i++) regs[i] = 4'($urandom);
      ack_wait = $urandom_range(0, 3);
      do_reset(6'($urandom));
      for (int c = 0; c < 150; c++) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", cnt, fails);
    $finish;
  end

endmodule
